// File: rtl/smart_cargo_tx_pedido.sv
// smart_cargo_tx_pedido: console-side 8N1 transmitter for SmartCargo requests.
// Requests {origem, destino, tipo} are queued in a small FIFO. Each one is packed
// into the byte {2'b00, tipo, destino, origem} and shifted out LSB first.
// Optional build macro SMART_CARGO_TX_VALIDA_EN: when defined, handshaked requests
// with tipo==0 or origem==destino are consumed and counted, but never queued.
module smart_cargo_tx_pedido #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_LOG2    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pedido_valido,
    output logic       pedido_pronto,
    input  logic [1:0] origem,
    input  logic [1:0] destino,
    input  logic [1:0] tipo,
    output logic       TX,
    output logic       ocupado,
    output logic       fila_vazia,
    output logic       fila_cheia,
    output logic [7:0] descartados,
    output logic [2:0] db_estado
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CNT_W = FIFO_LOG2 + 1;
    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PAY_W = 6;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ocup_q, ocup_d;
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 vazia_q, vazia_d;
    logic                 cheia_q, cheia_d;
    logic                 pronto_q, pronto_d;
    logic [PAY_W-1:0]     mem [DEPTH];

    logic accept;
    logic reject;
    logic push;
    logic pop;

    assign accept = pedido_valido && pronto_q;

`ifdef SMART_CARGO_TX_VALIDA_EN
    logic [7:0] desc_q, desc_d;

    assign reject = (tipo == 2'b00) || (origem == destino);

    // Saturating count of consumed-but-rejected requests
    always_comb begin
        desc_d = desc_q;
        if (accept && reject && (desc_q != 8'hFF)) begin
            desc_d = desc_q + 8'd1;
        end
    end

    // Rejection counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            desc_q <= 8'd0;
        end else begin
            desc_q <= desc_d;
        end
    end

    assign descartados = desc_q;
`else
    assign reject      = 1'b0;
    assign descartados = 8'd0;
`endif

    assign push = accept && !reject;

    // Next-state logic: serialiser FSM, FIFO bookkeeping and registered outputs
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (!vazia_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop     = 1'b1;
                shift_d = {2'b00, mem[rd_ptr_q]};
                idx_d   = 3'd0;
                tmr_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    state_d = S_DATA;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        vazia_d  = (count_d == '0);
        cheia_d  = (count_d == CNT_W'(DEPTH));
        pronto_d = !cheia_d;

        // Line level follows the state being entered so TX lines up with db_estado
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ocup_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ocup_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vazia_q  <= 1'b1;
            cheia_q  <= 1'b0;
            pronto_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ocup_q   <= ocup_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vazia_q  <= vazia_d;
            cheia_q  <= cheia_d;
            pronto_q <= pronto_d;
        end
    end

    // FIFO storage; contents are don't-care until a pointer covers them
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {tipo, destino, origem};
        end
    end

    assign TX            = tx_q;
    assign ocupado       = ocup_q;
    assign fila_vazia    = vazia_q;
    assign fila_cheia    = cheia_q;
    assign pedido_pronto = pronto_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_smart_cargo_tx_pedido.sv
// Directed bench for smart_cargo_tx_pedido with CLKS_PER_BIT=4, FIFO_LOG2=2.
module tb_smart_cargo_tx_pedido;

    localparam int unsigned CPB = 4;
    localparam int unsigned FL2 = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       pedido_valido;
    logic       pedido_pronto;
    logic [1:0] origem;
    logic [1:0] destino;
    logic [1:0] tipo;
    logic       TX;
    logic       ocupado;
    logic       fila_vazia;
    logic       fila_cheia;
    logic [7:0] descartados;
    logic [2:0] db_estado;

    int cyc     = 0;
    int occ_cnt = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    smart_cargo_tx_pedido #(
        .CLKS_PER_BIT(CPB),
        .FIFO_LOG2   (FL2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pedido_valido(pedido_valido),
        .pedido_pronto(pedido_pronto),
        .origem       (origem),
        .destino      (destino),
        .tipo         (tipo),
        .TX           (TX),
        .ocupado      (ocupado),
        .fila_vazia   (fila_vazia),
        .fila_cheia   (fila_cheia),
        .descartados  (descartados),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (ocupado) occ_cnt <= occ_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        pedido_valido = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Hold a request until it is taken; returns just after the accepting edge
    task automatic send_req(input string tag, input logic [1:0] o, input logic [1:0] d,
                            input logic [1:0] t);
        bit acc;
        int n;
        n = 0;
        origem = o; destino = d; tipo = t;
        pedido_valido = 1'b1;
        do begin
            acc = pedido_pronto;
            tick();
            n++;
        end while (!acc && n < 500);
        pedido_valido = 1'b0;
        check({tag, " accepted"}, 64'(acc), 64'd1);
    endtask

    function automatic logic [39:0] exp_line(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] r;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) r[i] = bits[i / 4];
        return r;
    endfunction

    // Wait for a start bit, then record the 40 line cycles of the frame
    task automatic expect_frame(input string tag, input logic [7:0] b, output int t_fall);
        logic [39:0] line;
        int n;
        n = 0;
        line = '0;
        t_fall = 0;
        while (TX !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, " start found"}, 64'(TX === 1'b0), 64'd1);
        if (TX === 1'b0) begin
            t_fall = cyc;
            for (int i = 0; i < 40; i++) begin
                line[i] = TX;
                tick();
            end
            check({tag, " line"}, 64'(line), 64'(exp_line(b)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int t_acc, t_fall, occ0, n, zeros, full_idx;
        int tf[6];
        logic cheia_seen;
        logic [5:0] req2 [6];
        logic [7:0] byte2 [6];
        logic [5:0] req3 [6];
        logic [7:0] byte3 [6];

        // {tipo, destino, origem} and the byte each must produce
        req2[0] = {2'd1, 2'd1, 2'd0}; byte2[0] = 8'h14;
        req2[1] = {2'd2, 2'd2, 2'd1}; byte2[1] = 8'h29;
        req2[2] = {2'd3, 2'd3, 2'd2}; byte2[2] = 8'h3E;
        req2[3] = {2'd1, 2'd0, 2'd3}; byte2[3] = 8'h13;
        req2[4] = {2'd2, 2'd2, 2'd0}; byte2[4] = 8'h28;
        req2[5] = {2'd3, 2'd3, 2'd1}; byte2[5] = 8'h3D;
        req3[0] = {2'd1, 2'd2, 2'd1}; byte3[0] = 8'h19;
        req3[1] = {2'd2, 2'd0, 2'd2}; byte3[1] = 8'h22;
        req3[2] = {2'd3, 2'd1, 2'd3}; byte3[2] = 8'h37;
        req3[3] = {2'd1, 2'd3, 2'd0}; byte3[3] = 8'h1C;
        req3[4] = {2'd2, 2'd1, 2'd2}; byte3[4] = 8'h26;
        req3[5] = {2'd1, 2'd2, 2'd3}; byte3[5] = 8'h1B;

        origem = 2'd0; destino = 2'd0; tipo = 2'd0;
        pedido_valido = 1'b0;
        reset = 1'b1;
        tick();

        // Reset values
        do_reset();
        check("rst TX", 64'(TX), 64'd1);
        check("rst ocupado", 64'(ocupado), 64'd0);
        check("rst fila_vazia", 64'(fila_vazia), 64'd1);
        check("rst fila_cheia", 64'(fila_cheia), 64'd0);
        check("rst pedido_pronto", 64'(pedido_pronto), 64'd1);
        check("rst descartados", 64'(descartados), 64'd0);
        check("rst db_estado", 64'(db_estado), 64'd0);

        // Test 1: single request, latency, bit pattern and busy window
        occ0 = occ_cnt;
        send_req("t1", 2'd1, 2'd3, 2'd2);
        t_acc = cyc;
        check("t1 TX idle after accept", 64'(TX), 64'd1);
        check("t1 fila_vazia after accept", 64'(fila_vazia), 64'd0);
        expect_frame("t1 0x2D", 8'h2D, t_fall);
        check("t1 latency", 64'(t_fall - t_acc), 64'd2);
        repeat (4) tick();
        check("t1 ocupado cycles", 64'(occ_cnt - occ0), 64'd41);
        check("t1 fila_vazia end", 64'(fila_vazia), 64'd1);

        // Test 2: six held requests, backpressure, order and spacing
        do_reset();
        full_idx = -1;
        cheia_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bit acc;
                    n = 0;
                    {tipo, destino, origem} = req2[i];
                    pedido_valido = 1'b1;
                    do begin
                        acc = pedido_pronto;
                        if (!acc && full_idx < 0) begin
                            full_idx = i;
                            cheia_seen = fila_cheia;
                        end
                        tick();
                        n++;
                    end while (!acc && n < 500);
                    check("t2 accepted", 64'(acc), 64'd1);
                end
                pedido_valido = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) expect_frame("t2 frame", byte2[i], tf[i]);
            end
        join
        check("t2 requests before full", 64'(full_idx), 64'd5);
        check("t2 fila_cheia when blocked", 64'(cheia_seen), 64'd1);
        for (int i = 1; i < 6; i++) check("t2 spacing", 64'(tf[i] - tf[i-1]), 64'd42);

        // Test 3: push and pop on the same edge with three queued
        do_reset();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send_req("t3 fill", req3[i][1:0], req3[i][3:2], req3[i][5:4]);
                n = 0;
                while (db_estado !== 3'd1 && n < 200) begin
                    tick();
                    n++;
                end
                check("t3 LOAD seen", 64'(db_estado), 64'd1);
                send_req("t3 E", req3[4][1:0], req3[4][3:2], req3[4][5:4]);
                check("t3 cheia after push+pop", 64'(fila_cheia), 64'd0);
                check("t3 vazia after push+pop", 64'(fila_vazia), 64'd0);
                send_req("t3 F", req3[5][1:0], req3[5][3:2], req3[5][5:4]);
                check("t3 cheia after 4th", 64'(fila_cheia), 64'd1);
                check("t3 pronto after 4th", 64'(pedido_pronto), 64'd0);
            end
            begin
                for (int i = 0; i < 6; i++) expect_frame("t3 frame", byte3[i], t_fall);
            end
        join

        // Test 4: reset mid-frame with one more request still queued
        do_reset();
        send_req("t4 a", 2'd1, 2'd3, 2'd2);
        send_req("t4 b", 2'd0, 2'd1, 2'd1);
        n = 0;
        while (TX !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("t4 start found", 64'(TX === 1'b0), 64'd1);
        repeat (9) tick();
        check("t4 TX before reset", 64'(TX), 64'd0);
        reset = 1'b1;
        tick();
        check("t4 TX after reset", 64'(TX), 64'd1);
        check("t4 db_estado after reset", 64'(db_estado), 64'd0);
        check("t4 fila_vazia after reset", 64'(fila_vazia), 64'd1);
        check("t4 ocupado after reset", 64'(ocupado), 64'd0);
        reset = 1'b0;
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            if (TX !== 1'b1) zeros++;
            tick();
        end
        check("t4 line quiet after reset", 64'(zeros), 64'd0);
        send_req("t4 new", 2'd1, 2'd3, 2'd2);
        expect_frame("t4 0x2D", 8'h2D, t_fall);

        // Test 5: origem == destino
        do_reset();
        send_req("t5", 2'd2, 2'd2, 2'd1);
`ifdef SMART_CARGO_TX_VALIDA_EN
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            if (TX !== 1'b1) zeros++;
            tick();
        end
        check("t5 no frame", 64'(zeros), 64'd0);
        check("t5 descartados", 64'(descartados), 64'd1);
        check("t5 fila_vazia", 64'(fila_vazia), 64'd1);
`else
        expect_frame("t5 0x1A", 8'h1A, t_fall);
        check("t5 descartados", 64'(descartados), 64'd0);
`endif

        // Test 6: tipo == 0 requests
        do_reset();
`ifdef SMART_CARGO_TX_VALIDA_EN
        origem = 2'd1; destino = 2'd2; tipo = 2'd0;
        pedido_valido = 1'b1;
        repeat (254) tick();
        check("t6 descartados 254", 64'(descartados), 64'd254);
        repeat (46) tick();
        pedido_valido = 1'b0;
        check("t6 descartados saturated", 64'(descartados), 64'd255);
        check("t6 fila_vazia", 64'(fila_vazia), 64'd1);
        send_req("t6 valid", 2'd3, 2'd0, 2'd2);
        expect_frame("t6 0x23", 8'h23, t_fall);
        check("t6 descartados held", 64'(descartados), 64'd255);
`else
        send_req("t6", 2'd1, 2'd2, 2'd0);
        expect_frame("t6 0x09", 8'h09, t_fall);
        check("t6 descartados", 64'(descartados), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
